// File: rtl/mopshub_bus_init_seq_pkg.sv
// Shared types and defaults for the MOPSHUB CAN-bus power-up/trim sequencer.
// Optional feature macro used by the sequencer: MOPSHUB_TRIM_RETRY_EN.
package mopshub_bus_init_seq_pkg;

    localparam int DEF_SETTLE_CYC   = 1024;
    localparam int DEF_RST_CYC      = 8;
    localparam int DEF_TRIM_TIMEOUT = 4096;
    localparam int DEF_MAX_RETRY    = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_POWER,
        ST_RST,
        ST_TRIM_REQ,
        ST_TRIM_WAIT,
        ST_BUS_END,
        ST_DONE
    } bus_init_state_e;

    // Width able to index n items, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mopshub_bus_init_seq_if.sv
// Handshake bundle between the bus-init sequencer, the MOPSHUB core and the trim engine.
// The sequencer connects through the slave modport; its controller uses master.
interface mopshub_bus_init_seq_if
    import mopshub_bus_init_seq_pkg::*;
#(
    parameter int N_BUSES = 32,
    parameter int CNT_W   = cnt_width(N_BUSES)
) ();

    logic               start_init;
    logic [CNT_W-1:0]   n_buses;
    logic [N_BUSES-1:0] bus_mask;
    logic               osc_auto_trim;
    logic               trim_done;
    logic               trim_ok;

    logic               power_bus_en;
    logic [CNT_W-1:0]   power_bus_cnt;
    logic               rst_bus;
    logic               start_trim_ack;
    logic               end_trim_bus;
    logic               end_power_init;
    logic               busy;
    logic [N_BUSES-1:0] bus_ok;
    logic [CNT_W:0]     fail_cnt;

    modport slave (
        input  start_init, n_buses, bus_mask, osc_auto_trim, trim_done, trim_ok,
        output power_bus_en, power_bus_cnt, rst_bus, start_trim_ack, end_trim_bus,
               end_power_init, busy, bus_ok, fail_cnt
    );

    modport master (
        output start_init, n_buses, bus_mask, osc_auto_trim, trim_done, trim_ok,
        input  power_bus_en, power_bus_cnt, rst_bus, start_trim_ack, end_trim_bus,
               end_power_init, busy, bus_ok, fail_cnt
    );

endinterface

// File: rtl/mopshub_bus_init_seq_timer.sv
// Loadable down-counter shared by the settle, bus-reset and trim-timeout phases.
// o_expired is high whenever the count sits at zero.
module mopshub_seq_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/mopshub_bus_init_seq.sv
// Walks enabled CAN buses one at a time: power on, settle, reset pulse, oscillator trim.
// Define MOPSHUB_TRIM_RETRY_EN to retry a failed trim up to MAX_RETRY times per bus.
module mopshub_bus_init_seq
    import mopshub_bus_init_seq_pkg::*;
#(
    parameter int N_BUSES      = 32,
    parameter int CNT_W        = cnt_width(N_BUSES),
    parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
    parameter int RST_CYC      = DEF_RST_CYC,
    parameter int TRIM_TIMEOUT = DEF_TRIM_TIMEOUT,
    parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    mopshub_bus_init_seq_if.slave   bus
);

    localparam int TMR_W = cnt_width(max3(SETTLE_CYC, RST_CYC, TRIM_TIMEOUT));
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] RST_LD    = TMR_W'(RST_CYC - 1);
    localparam logic [TMR_W-1:0] TRIM_LD   = TMR_W'(TRIM_TIMEOUT - 1);
    localparam logic [CNT_W:0]   LAST_IDX  = (CNT_W + 1)'(N_BUSES - 1);

    if (N_BUSES < 2 || N_BUSES > 64 || MAX_RETRY < 0 || SETTLE_CYC < 1 ||
        RST_CYC < 1 || TRIM_TIMEOUT < 1) begin : g_bad_param
        $error("mopshub_bus_init_seq: parameter out of range");
    end

    bus_init_state_e    r_state, w_next_state;
    logic [CNT_W:0]     r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_nbus;
    logic [N_BUSES-1:0] r_mask;
    logic [N_BUSES-1:0] r_bus_ok;
    logic [CNT_W:0]     r_fail_cnt;

    logic               w_start, w_idx_inc, w_sel_bus, w_pass, w_fail;
    logic               w_tmr_load, w_tmr_en, w_tmr_expired;
    logic [TMR_W-1:0]   w_tmr_val;
    logic               w_idx_valid;

    // The index is one bit wider than needed so the walk past the last bus never wraps.
    assign w_idx_valid = (r_idx <= {1'b0, r_nbus}) && (r_idx <= LAST_IDX);

`ifdef MOPSHUB_TRIM_RETRY_EN
    localparam int RTY_W = cnt_width(MAX_RETRY + 1);
    localparam logic [RTY_W-1:0] RETRY_LIM = RTY_W'(MAX_RETRY);

    logic [RTY_W-1:0] r_retry;
    logic             w_retry;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_retry <= '0;
        end else if (w_sel_bus) begin
            r_retry <= '0;
        end else if (w_retry) begin
            r_retry <= r_retry + 1'b1;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_idx_inc    = 1'b0;
        w_sel_bus    = 1'b0;
        w_pass       = 1'b0;
        w_fail       = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;
        w_tmr_en     = 1'b0;
`ifdef MOPSHUB_TRIM_RETRY_EN
        w_retry      = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.start_init) begin
                    w_start      = 1'b1;
                    w_next_state = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!w_idx_valid) begin
                    w_next_state = ST_DONE;
                end else if (!r_mask[r_idx[CNT_W-1:0]]) begin
                    w_idx_inc = 1'b1;
                end else begin
                    w_sel_bus    = 1'b1;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = SETTLE_LD;
                    w_next_state = ST_POWER;
                end
            end
            ST_POWER: begin
                w_tmr_en = 1'b1;
                if (w_tmr_expired) begin
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = RST_LD;
                    w_next_state = ST_RST;
                end
            end
            ST_RST: begin
                w_tmr_en = 1'b1;
                if (w_tmr_expired) begin
                    if (bus.osc_auto_trim) begin
                        w_next_state = ST_TRIM_REQ;
                    end else begin
                        w_pass       = 1'b1;
                        w_next_state = ST_BUS_END;
                    end
                end
            end
            ST_TRIM_REQ: begin
                w_tmr_load   = 1'b1;
                w_tmr_val    = TRIM_LD;
                w_next_state = ST_TRIM_WAIT;
            end
            ST_TRIM_WAIT: begin
                w_tmr_en = 1'b1;
                // A trim answer arriving on the expiry cycle still counts as the answer.
                if (bus.trim_done && bus.trim_ok) begin
                    w_pass       = 1'b1;
                    w_next_state = ST_BUS_END;
                end else if (bus.trim_done || w_tmr_expired) begin
`ifdef MOPSHUB_TRIM_RETRY_EN
                    if (r_retry < RETRY_LIM) begin
                        w_retry      = 1'b1;
                        w_next_state = ST_TRIM_REQ;
                    end else begin
                        w_fail       = 1'b1;
                        w_next_state = ST_BUS_END;
                    end
`else
                    w_fail       = 1'b1;
                    w_next_state = ST_BUS_END;
`endif
                end
            end
            ST_BUS_END: begin
                w_idx_inc    = 1'b1;
                w_next_state = ST_SCAN;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx      <= '0;
            r_cnt      <= '0;
            r_nbus     <= '0;
            r_mask     <= '0;
            r_bus_ok   <= '0;
            r_fail_cnt <= '0;
        end else begin
            if (w_start) begin
                r_nbus     <= bus.n_buses;
                r_mask     <= bus.bus_mask;
                r_bus_ok   <= '0;
                r_fail_cnt <= '0;
                r_idx      <= '0;
            end
            if (w_idx_inc) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_sel_bus) begin
                r_cnt <= r_idx[CNT_W-1:0];
            end
            if (w_pass) begin
                r_bus_ok[r_cnt] <= 1'b1;
            end
            if (w_fail) begin
                r_bus_ok[r_cnt] <= 1'b0;
                r_fail_cnt      <= r_fail_cnt + 1'b1;
            end
        end
    end

    mopshub_seq_timer #(
        .W          (TMR_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_expired  (w_tmr_expired)
    );

    assign bus.power_bus_en   = (r_state == ST_POWER) || (r_state == ST_RST) ||
                                (r_state == ST_TRIM_REQ) || (r_state == ST_TRIM_WAIT);
    assign bus.power_bus_cnt  = r_cnt;
    assign bus.rst_bus        = (r_state == ST_RST);
    assign bus.start_trim_ack = (r_state == ST_TRIM_REQ);
    assign bus.end_trim_bus   = (r_state == ST_BUS_END);
    assign bus.end_power_init = (r_state == ST_DONE);
    assign bus.busy           = (r_state != ST_IDLE);
    assign bus.bus_ok         = r_bus_ok;
    assign bus.fail_cnt       = r_fail_cnt;

endmodule

// File: tb/tb_mopshub_bus_init_seq.sv
// Directed bench for mopshub_bus_init_seq with 4 buses and shortened phase lengths.
// Expectations follow MOPSHUB_TRIM_RETRY_EN when the bench is built with it.
module tb_mopshub_bus_init_seq;

    localparam int NB       = 4;
    localparam int SETTLE   = 20;
    localparam int RSTC     = 4;
    localparam int TMO      = 150;
    localparam int MRETRY   = 2;
    localparam int TRIM_DLY = 100;
`ifdef MOPSHUB_TRIM_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    typedef struct {
        logic [NB-1:0] mask;
        logic [1:0]    nbus;
        logic          autoTrim;
        logic [NB-1:0] silent;
        int            nack1;
        logic [NB-1:0] expOk;
        int            expFail;
        int            expAckTot;
        int            expAck1;
        int            expGap0;
        int            expGap2;
        int            expDone;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mopshub_bus_init_seq_if #(.N_BUSES(NB)) busIf ();

    mopshub_bus_init_seq #(
        .N_BUSES      (NB),
        .SETTLE_CYC   (SETTLE),
        .RST_CYC      (RSTC),
        .TRIM_TIMEOUT (TMO),
        .MAX_RETRY    (MRETRY)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (busIf)
    );

    int testsRun = 0;
    int failCnt  = 0;

    // Control flags written only by the main sequence.
    logic          clrReq = 1'b0;
    logic          spurReq = 1'b0;
    logic [NB-1:0] silent = '0;
    int            nack[NB] = '{default: 0};

    // Statistics written only by the monitor.
    int cyc = 0;
    int ackCnt[NB];
    int lastAck[NB];
    int gap[NB];
    int endCnt, rstBusCyc, doneCyc, endWithPower;
    logic [NB-1:0] poweredMask;
    int endOrder[$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (clrReq) begin
                for (int i = 0; i < NB; i++) begin
                    ackCnt[i] = 0; lastAck[i] = 0; gap[i] = 0;
                end
                endCnt = 0; rstBusCyc = 0; doneCyc = 0; endWithPower = 0;
                poweredMask = '0;
                endOrder.delete();
            end else begin
                if (busIf.power_bus_en) poweredMask[busIf.power_bus_cnt] = 1'b1;
                if (busIf.rst_bus) rstBusCyc++;
                if (busIf.start_trim_ack) begin
                    ackCnt[busIf.power_bus_cnt]++;
                    lastAck[busIf.power_bus_cnt] = cyc;
                end
                if (busIf.end_trim_bus) begin
                    endCnt++;
                    endOrder.push_back(int'(busIf.power_bus_cnt));
                    gap[busIf.power_bus_cnt] = cyc - lastAck[busIf.power_bus_cnt];
                    if (busIf.power_bus_en) endWithPower++;
                end
                if (busIf.end_power_init) doneCyc = cyc;
            end
        end
    end

    // Trim engine model: answers TRIM_DLY cycles after a request; bus 'b' fails its first nack[b] tries.
    initial begin
        int waitCnt;
        int curBus;
        int attempt[NB];
        waitCnt = 0;
        curBus = 0;
        attempt = '{default: 0};
        busIf.trim_done = 1'b0;
        busIf.trim_ok   = 1'b0;
        forever begin
            @(negedge clk);
            busIf.trim_done = 1'b0;
            busIf.trim_ok   = 1'b0;
            if (clrReq) begin
                attempt = '{default: 0};
                waitCnt = 0;
            end
            if (spurReq) begin
                busIf.trim_done = 1'b1;
                busIf.trim_ok   = 1'b1;
            end
            if (waitCnt > 0) begin
                waitCnt--;
                if (waitCnt == 0) begin
                    busIf.trim_done = 1'b1;
                    busIf.trim_ok   = (attempt[curBus] > nack[curBus]);
                end
            end
            if (busIf.start_trim_ack) begin
                curBus = int'(busIf.power_bus_cnt);
                attempt[curBus]++;
                waitCnt = silent[curBus] ? 0 : TRIM_DLY;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCnt++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NB-1:0] mask, input logic [1:0] nbus, input logic autoTrim,
                                 output int startCyc);
        @(negedge clk);
        #1 clrReq = 1'b1;
        @(negedge clk);
        #1 clrReq = 1'b0;
        busIf.bus_mask      = mask;
        busIf.n_buses       = nbus;
        busIf.osc_auto_trim = autoTrim;
        busIf.start_init    = 1'b1;
        startCyc            = cyc;
        @(negedge clk);
        #1 busIf.start_init = 1'b0;
    endtask

    task automatic waitDone(input int maxCyc, output bit ok, output logic [NB-1:0] okMask,
                            output int fails, output bit busyAt, output bit busyAfter);
        ok = 1'b0; okMask = '0; fails = 0; busyAt = 1'b0; busyAfter = 1'b1;
        for (int i = 0; i < maxCyc && !ok; i++) begin
            @(negedge clk);
            #1;
            if (busIf.end_power_init) begin
                ok     = 1'b1;
                okMask = busIf.bus_ok;
                fails  = int'(busIf.fail_cnt);
                busyAt = busIf.busy;
                @(negedge clk);
                #1 busyAfter = busIf.busy;
            end
        end
    endtask

    task automatic waitPowerAny(input int maxCyc, output bit found, output int cnt);
        found = 1'b0; cnt = -1;
        for (int i = 0; i < maxCyc && !found; i++) begin
            @(negedge clk);
            #1;
            if (busIf.power_bus_en) begin
                found = 1'b1;
                cnt   = int'(busIf.power_bus_cnt);
            end
        end
    endtask

    task automatic waitPowerBus(input int busIdx, input int maxCyc, output bit found);
        found = 1'b0;
        for (int i = 0; i < maxCyc && !found; i++) begin
            @(negedge clk);
            #1;
            if (busIf.power_bus_en && int'(busIf.power_bus_cnt) == busIdx) found = 1'b1;
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_power_bus_en"},   busIf.power_bus_en,   0);
        checkOutput({tag, "_power_bus_cnt"},  busIf.power_bus_cnt,  0);
        checkOutput({tag, "_rst_bus"},        busIf.rst_bus,        0);
        checkOutput({tag, "_start_trim_ack"}, busIf.start_trim_ack, 0);
        checkOutput({tag, "_end_trim_bus"},   busIf.end_trim_bus,   0);
        checkOutput({tag, "_end_power_init"}, busIf.end_power_init, 0);
        checkOutput({tag, "_busy"},           busIf.busy,           0);
        checkOutput({tag, "_bus_ok"},         busIf.bus_ok,         0);
        checkOutput({tag, "_fail_cnt"},       busIf.fail_cnt,       0);
    endtask

    vec_t vecs[8];

    initial begin
        int startCyc, nPow, cnt;
        bit ok, busyAt, busyAfter, found;
        logic [NB-1:0] okMask, expPow;
        int fails;
        logic [63:0] encAct, encExp;

        vecs[0] = '{4'hF, 2'd3, 1'b1, 4'h0, 0, 4'hF, 0, 4, 1, TRIM_DLY+1, TRIM_DLY+1, 0};
        vecs[1] = '{4'hA, 2'd3, 1'b1, 4'h0, 0, 4'hA, 0, 2, 1, 0, 0, 0};
        vecs[2] = '{4'hF, 2'd3, 1'b1, 4'h4, 0, 4'hB, 1, RETRY ? 6 : 4, 1, TRIM_DLY+1, TMO+1, 0};
        vecs[3] = '{4'hF, 2'd3, 1'b1, 4'h0, 2, RETRY ? 4'hF : 4'hD, RETRY ? 0 : 1,
                    RETRY ? 6 : 4, RETRY ? 3 : 1, 0, 0, 0};
        vecs[4] = '{4'h0, 2'd3, 1'b1, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 6};
        vecs[5] = '{4'hF, 2'd1, 1'b1, 4'h0, 0, 4'h3, 0, 2, 1, 0, 0, 0};
        vecs[6] = '{4'hF, 2'd3, 1'b0, 4'h0, 0, 4'hF, 0, 0, 0, 0, 0, 4*(SETTLE+RSTC+2)+2};
        vecs[7] = '{4'h8, 2'd3, 1'b0, 4'h0, 0, 4'h8, 0, 0, 0, 0, 0, 4+SETTLE+RSTC+3};

        busIf.start_init    = 1'b0;
        busIf.n_buses       = '0;
        busIf.bus_mask      = '0;
        busIf.osc_auto_trim = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkIdleOutputs("reset");
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            silent   = vecs[v].silent;
            nack[1]  = vecs[v].nack1;
            applyStimulus(vecs[v].mask, vecs[v].nbus, vecs[v].autoTrim, startCyc);
            waitDone(8000, ok, okMask, fails, busyAt, busyAfter);
            checkOutput($sformatf("v%0d_done_seen", v), ok, 1);
            checkOutput($sformatf("v%0d_bus_ok", v), okMask, vecs[v].expOk);
            checkOutput($sformatf("v%0d_fail_cnt", v), fails, vecs[v].expFail);
            checkOutput($sformatf("v%0d_busy_at_done", v), busyAt, 1);
            checkOutput($sformatf("v%0d_busy_after", v), busyAfter, 0);
            expPow = '0;
            nPow = 0;
            encExp = '0;
            for (int i = 0; i < NB; i++) begin
                if (i <= int'(vecs[v].nbus) && vecs[v].mask[i]) begin
                    expPow[i] = 1'b1;
                    nPow++;
                    encExp = (encExp << 4) | 64'(i + 1);
                end
            end
            encAct = '0;
            foreach (endOrder[k]) encAct = (encAct << 4) | 64'(endOrder[k] + 1);
            checkOutput($sformatf("v%0d_powered_set", v), poweredMask, expPow);
            checkOutput($sformatf("v%0d_end_trim_cnt", v), endCnt, nPow);
            checkOutput($sformatf("v%0d_end_order", v), encAct, encExp);
            checkOutput($sformatf("v%0d_rst_bus_cycles", v), rstBusCyc, nPow * RSTC);
            checkOutput($sformatf("v%0d_end_with_power", v), endWithPower, 0);
            checkOutput($sformatf("v%0d_ack_total", v),
                        ackCnt[0] + ackCnt[1] + ackCnt[2] + ackCnt[3], vecs[v].expAckTot);
            checkOutput($sformatf("v%0d_ack_bus1", v), ackCnt[1], vecs[v].expAck1);
            if (vecs[v].expGap0 != 0) checkOutput($sformatf("v%0d_gap_bus0", v), gap[0], vecs[v].expGap0);
            if (vecs[v].expGap2 != 0) checkOutput($sformatf("v%0d_gap_bus2", v), gap[2], vecs[v].expGap2);
            if (vecs[v].expDone != 0) checkOutput($sformatf("v%0d_done_cycle", v), doneCyc - startCyc, vecs[v].expDone);
        end
        silent  = '0;
        nack[1] = 0;

        // Abort during POWER of bus 2, then restart and try a start_init while busy.
        applyStimulus(4'hF, 2'd3, 1'b0, startCyc);
        waitPowerBus(2, 1000, found);
        checkOutput("abort_reach_bus2", found, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkIdleOutputs("abort");
        rst = 1'b0;
        applyStimulus(4'hF, 2'd3, 1'b0, startCyc);
        waitPowerAny(50, found, cnt);
        checkOutput("restart_first_bus", cnt, 0);
        busIf.bus_mask   = 4'h1;
        busIf.n_buses    = 2'd0;
        busIf.start_init = 1'b1;
        @(negedge clk);
        #1 busIf.start_init = 1'b0;
        waitDone(2000, ok, okMask, fails, busyAt, busyAfter);
        checkOutput("restart_done_seen", ok, 1);
        checkOutput("restart_bus_ok", okMask, 4'hF);
        checkOutput("restart_end_trim_cnt", endCnt, 4);

        // A trim_done while powering must not be taken as the answer for the later request.
        silent = 4'h1;
        applyStimulus(4'h1, 2'd0, 1'b1, startCyc);
        waitPowerAny(50, found, cnt);
        spurReq = 1'b1;
        @(negedge clk);
        #1 spurReq = 1'b0;
        waitDone(2000, ok, okMask, fails, busyAt, busyAfter);
        checkOutput("spurious_done_seen", ok, 1);
        checkOutput("spurious_bus_ok", okMask, 4'h0);
        checkOutput("spurious_fail_cnt", fails, 1);
        checkOutput("spurious_acks", ackCnt[0], RETRY ? 3 : 1);
        silent = '0;

        $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
        $finish;
    end

endmodule
